// File: rtl/mux_2x1_rr_arbiter.sv
// mux_2x1_rr_arbiter: two-requester round-robin arbiter driving a 2x1 mux into one registered output beat.
// Define MUX_2X1_RR_ARBITER_BURST_LOCK_EN to hold the grant across a burst until i_last.
module mux_2x1_rr_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              i_valid,
  input  logic [2*DATA_WIDTH-1:0] i_data_bus,
  input  logic [1:0]              i_last,
  output logic [1:0]              o_ready,
  output logic                    o_valid,
  output logic [DATA_WIDTH-1:0]   o_data_bus,
  input  logic                    i_ready,
  output logic                    o_mux_en,
  output logic                    o_mux_cmd,
  output logic [1:0]              o_grant
);
  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;
  state_t                  state_q, state_d;
  logic                    rr_last_q, rr_last_d, valid_q, valid_d, ld, gidx;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [1:0]              elig, grant, last;
`ifdef MUX_2X1_RR_ARBITER_BURST_LOCK_EN
  assign last = i_last;
`else
  // every beat ends its own burst, so the FSM never leaves IDLE
  assign last = i_last | 2'b11;
`endif
  always_comb begin
    elig      = state_q == LOCK0 ? {1'b0, i_valid[0]} : state_q == LOCK1 ? {i_valid[1], 1'b0} : i_valid;
    grant     = rst ? 2'b00 : &elig ? (rr_last_q ? 2'b01 : 2'b10) : elig;
    gidx      = grant[1];
    ld        = |grant && (!valid_q || i_ready);
    rr_last_d = ld ? gidx : rr_last_q;
    valid_d   = ld | (valid_q & ~i_ready);
    data_d    = ld ? (gidx ? i_data_bus[DATA_WIDTH +: DATA_WIDTH] : i_data_bus[DATA_WIDTH-1:0]) : data_q;
    state_d   = !ld ? state_q : last[gidx] ? IDLE : gidx ? LOCK1 : LOCK0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
      valid_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
    end
  end
  assign o_grant    = grant;
  assign o_ready    = {2{ld}} & grant;
  assign o_mux_en   = ld;
  assign o_mux_cmd  = ld & gidx;
  assign o_valid    = valid_q;
  assign o_data_bus = data_q;
endmodule

// File: doc/mux_2x1_rr_arbiter.md
MUX_2X1_RR_ARBITER -- requirements
Module: mux_2x1_rr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of one beat.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 i_valid  input  2  per-requester beat valid; bit 0 = low branch, bit 1 = high branch.
REQ-005 i_data_bus  input  2*DATA_WIDTH  requester data; low branch [DATA_WIDTH-1:0], high branch [DATA_WIDTH+:DATA_WIDTH].
REQ-006 i_last  input  2  per-requester last-beat-of-burst flag; meaningful only with i_valid.
REQ-007 o_ready  output  2  per-requester accept; beat k transfers when i_valid[k] and o_ready[k] in the same cycle.
REQ-008 o_valid  output  1  registered output beat valid.
REQ-009 o_data_bus  output  DATA_WIDTH  registered output beat.
REQ-010 i_ready  input  1  downstream accept; output beat retires when o_valid and i_ready.
REQ-011 o_mux_en  output  1  mux enable to the 2x1 mux stage; high exactly in cycles where a beat is loaded.
REQ-012 o_mux_cmd  output  1  mux command; 1 selects high branch, 0 selects low branch.
REQ-013 o_grant  output  2  one-hot current grant, zero when no requester is eligible.

Function
REQ-014 Load condition ld SHALL be: an eligible granted requester valid AND (o_valid==0 OR i_ready==1); full-throughput pass-through with one output register.
REQ-015 Latency SHALL be one cycle: beat accepted in cycle N appears on o_valid/o_data_bus in cycle N+1.
REQ-016 Arbitration in IDLE: single valid requester wins; both valid -> requester not equal to rr_last wins.
REQ-017 rr_last SHALL update to the loaded requester index on every ld; unchanged otherwise.
REQ-018 o_ready[k] SHALL equal ld AND o_grant[k] (combinational); never both bits high.
REQ-019 o_mux_en SHALL equal ld; o_mux_cmd SHALL equal granted index when ld, else 0.
REQ-020 o_data_bus SHALL load the selected branch on ld and hold otherwise; o_valid SHALL set on ld, clear on (i_ready AND NOT ld), hold otherwise.
REQ-021 While o_valid=1 and i_ready=0, o_valid and o_data_bus SHALL remain stable and both o_ready bits SHALL be 0.
REQ-022 FSM states IDLE, LOCK0, LOCK1 (burst lock, see Configuration); in LOCKk only requester k is eligible; other requester stalls even if valid.
REQ-023 LOCKk -> IDLE on ld of requester k with i_last[k]=1; IDLE -> LOCKk on ld of requester k with i_last[k]=0; otherwise state holds.
REQ-024 Neither requester valid (or locked requester idle): o_grant=0, ld=0, output register drains normally.

Reset
REQ-025 rst asserted SHALL immediately force: o_valid=0, o_data_bus=0, state=IDLE, rr_last=1 (requester 0 wins first tie).
REQ-026 Combinational outputs during reset: o_ready=0, o_mux_en=0, o_mux_cmd=0, o_grant=0.
REQ-027 Reset mid-burst SHALL drop the lock and discard the registered beat; no beat is delivered after deassertion without a new ld.

Configuration
REQ-028 Macro MUX_2X1_RR_ARBITER_BURST_LOCK_EN defined: REQ-022/023 active, grant held across bursts until i_last.
REQ-029 Macro undefined: i_last ignored (treated as 1), FSM remains IDLE, round-robin on every beat; port i_last still present.

Verification
REQ-030 Both valid continuously, i_ready=1, data low=0xA, high=0xB, no lock -> output 0xA,0xB,0xA,0xB... one beat per cycle, o_mux_cmd 0,1,0,1.
REQ-031 Only i_valid[1] with 0x55, i_ready=1 -> o_ready=2'b10, o_mux_cmd=1, o_data_bus=0x55 next cycle; repeats every cycle.
REQ-032 o_valid=1 holding 0x11, i_ready=0 for 3 cycles, both requesters valid -> o_ready=0, output stable 0x11; i_ready=1 then retires 0x11 and loads next in same cycle.
REQ-033 Lock macro on: requester 0 sends 3 beats (i_last only on 3rd) while requester 1 valid -> 3 contiguous requester-0 beats, then requester 1 granted.
REQ-034 Lock macro on: rst asserted after 1st beat of a 3-beat burst -> o_valid=0, state IDLE; after release with both valid, requester 0 wins (rr_last=1).
